// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and helpers for the LSU memory controller.
// Direction flags, FSM state encoding and byte-lane utilities.
package lsu_mem_ctrl_pkg;

    localparam logic READ_FLAG  = 1'b0;
    localparam logic WRITE_FLAG = 1'b1;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRead  = 3'd1,
        StRtail = 3'd2,
        StWrite = 3'd3,
        StDone  = 3'd4
    } state_e;

    function automatic logic size_legal(input logic [2:0] size);
        return (size == 3'd1) || (size == 3'd2) || (size == 3'd4);
    endfunction

    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [7:0] b,
                                             input logic [1:0] idx);
        logic [31:0] res;
        res = word;
        res[{idx, 3'b000} +: 8] = b;
        return res;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl.sv
// Responder for LSU load/store requests over a byte-wide RAM/IO bus.
// Serialises little-endian beats, assembles load data and pulses completion.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [1:0]  IO_TAG     = 2'b11
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  en_signal_from_lsu,
    input  logic [ADDR_WIDTH-1:0] addr_from_lsu,
    input  logic [31:0]           data_from_lsu,
    input  logic                  rw_flag_from_lsu,
    input  logic [2:0]            size_from_lsu,
    output logic                  ok_flag_to_lsu,
    output logic [31:0]           data_to_lsu,
    input  logic                  rollback_flag_from_rob,
    input  logic                  io_buffer_full,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    output logic                  busy
);

    state_e                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic                  rw_q, rw_d;
    logic [2:0]            size_q, size_d;
    logic [31:0]           asm_q, asm_d;
    logic                  ok_q, ok_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
    logic [7:0]            mem_dout_q, mem_dout_d;
    logic                  mem_wr_q, mem_wr_d;

    logic [2:0]            size_m1;
    logic [1:0]            last_beat;
    logic                  io_stall;
    logic [ADDR_WIDTH-1:0] beat_addr;

    // Sizes 1/2/4 map to final beat indices 0/1/3.
    assign size_m1   = size_q - 3'd1;
    assign last_beat = size_m1[1:0];
    assign io_stall  = (addr_q[17:16] == IO_TAG) && io_buffer_full;
    assign beat_addr = addr_q + ADDR_WIDTH'(cnt_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rw_d       = rw_q;
        size_d     = size_q;
        asm_d      = asm_q;
        ok_d       = ok_q;
        rdata_d    = rdata_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;

        unique case (state_q)
            StIdle: begin
                mem_wr_d = 1'b0;
                ok_d     = 1'b0;
                if (en_signal_from_lsu) begin
                    addr_d = addr_from_lsu;
                    data_d = data_from_lsu;
                    rw_d   = rw_flag_from_lsu;
                    size_d = size_from_lsu;
                    cnt_d  = 2'd0;
                    asm_d  = 32'd0;
                    if (!size_legal(size_from_lsu)) begin
                        state_d = StDone;
                    end else if (rw_flag_from_lsu == READ_FLAG) begin
                        state_d = StRead;
                    end else begin
                        state_d = StWrite;
                    end
                end
            end
            StRead: begin
                mem_a_d  = beat_addr;
                mem_wr_d = 1'b0;
                // The byte on mem_din belongs to the address issued one beat ago.
                if (cnt_q != 2'd0) begin
                    asm_d = put_byte(asm_q, mem_din, cnt_q - 2'd1);
                end
                if (cnt_q == last_beat) begin
                    state_d = StRtail;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StRtail: begin
                asm_d   = put_byte(asm_q, mem_din, cnt_q);
                state_d = StDone;
            end
            StWrite: begin
                if (io_stall) begin
                    mem_wr_d = 1'b0;
                end else begin
                    mem_a_d    = beat_addr;
                    mem_dout_d = word_byte(data_q, cnt_q);
                    mem_wr_d   = 1'b1;
                    if (cnt_q == last_beat) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            StDone: begin
                mem_wr_d = 1'b0;
                ok_d     = 1'b1;
                rdata_d  = asm_q;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Loads are squashed on rollback; stores always run to completion.
        if (rollback_flag_from_rob && (rw_q == READ_FLAG) &&
            (state_q == StRead || state_q == StRtail || state_q == StDone)) begin
            state_d  = StIdle;
            mem_wr_d = 1'b0;
            ok_d     = 1'b0;
            rdata_d  = rdata_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q    <= StIdle;
            cnt_q      <= 2'd0;
            addr_q     <= '0;
            data_q     <= 32'd0;
            rw_q       <= READ_FLAG;
            size_q     <= 3'd0;
            asm_q      <= 32'd0;
            ok_q       <= 1'b0;
            rdata_q    <= 32'd0;
            mem_a_q    <= '0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rw_q       <= rw_d;
            size_q     <= size_d;
            asm_q      <= asm_d;
            ok_q       <= ok_d;
            rdata_q    <= rdata_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
        end
    end

    assign ok_flag_to_lsu = ok_q;
    assign data_to_lsu    = rdata_q;
    assign mem_a          = mem_a_q;
    assign mem_dout       = mem_dout_q;
    assign mem_wr         = mem_wr_q;
    assign busy           = (state_q != StIdle);

endmodule
